reg_dump: RTL and testbench

REG_DUMP -- requirements
Module: reg_dump

---
 rtl/reg_dump.sv | 103 ++++++++++
 tb/tb_reg_dump.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/reg_dump.sv
// reg_dump: walks register indices FIRST..LAST and reads each one through a
// combinational register-file port. Each value is captured and presented as
// one word on a valid/ready output stream. DONE pulses once after the last
// word has been accepted.
//
// Output handshake: dvalid rises when a word is captured. dout, didx and
// dvalid then hold steady until an edge that samples dvalid && dready, and
// that edge retires the word. Register-file writes made while a word waits do
// not disturb it, because the word is held in dout.
module reg_dump #(
    parameter int FIRST = 0,   // first register index read out
    parameter int LAST  = 31   // last register index read out, FIRST <= LAST <= 31
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic        abort,
    output logic [4:0]  rd_addr,
    input  logic [31:0] rd_data,
    output logic [31:0] dout,
    output logic [4:0]  didx,
    output logic        dvalid,
    input  logic        dready,
    output logic        busy,
    output logic        done,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ   = 2'd1,
        SEND   = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam logic [4:0] FIRST_ADDR = FIRST[4:0];
    localparam logic [4:0] LAST_ADDR  = LAST[4:0];

    state_t state;

    // The state is exposed directly so that checkers can follow the walk.
    assign state_dbg = state;

    // Dump sequencer. Clear overrides everything. Abort overrides any active
    // state, including a handshake on the same edge. Every output is registered.
    always_ff @(posedge clk) begin
        if (clr) begin
            state   <= IDLE;
            rd_addr <= FIRST_ADDR;
            dout    <= '0;
            didx    <= '0;
            dvalid  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else if (abort && state != IDLE) begin
            state   <= IDLE;
            rd_addr <= FIRST_ADDR;
            dvalid  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // A start that arrives together with abort is dropped.
                    if (start && !abort) begin
                        state   <= READ;
                        rd_addr <= FIRST_ADDR;
                        busy    <= 1'b1;
                    end
                end
                READ: begin
                    dout   <= rd_data;
                    didx   <= rd_addr;
                    dvalid <= 1'b1;
                    state  <= SEND;
                end
                SEND: begin
                    if (dready) begin
                        dvalid <= 1'b0;
                        // The walk stops at LAST, so rd_addr never wraps.
                        if (rd_addr == LAST_ADDR) begin
                            done  <= 1'b1;
                            state <= FINISH;
                        end else begin
                            rd_addr <= rd_addr + 5'd1;
                            state   <= READ;
                        end
                    end
                end
                FINISH: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    rd_addr <= FIRST_ADDR;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_dump.sv
// Directed bench for reg_dump. It covers a full 0..31 walk, a stalled word
// with a register rewrite, abort, a mid-dump clear, and a single-register dump.
module tb_reg_dump;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        clr, start, abort, dready;
    logic        start1, dready1;
    logic [4:0]  rd_addr, didx, rd_addr1, didx1;
    logic [31:0] rd_data, dout, rd_data1, dout1;
    logic        dvalid, busy, done, dvalid1, busy1, done1;
    logic [1:0]  state_dbg, state_dbg1;

    logic [31:0] regs  [32];
    logic [31:0] regs1 [32];

    assign rd_data  = regs[rd_addr];
    assign rd_data1 = regs1[rd_addr1];

    reg_dump dut (
        .clk(clk), .clr(clr), .start(start), .abort(abort),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .dout(dout), .didx(didx), .dvalid(dvalid), .dready(dready),
        .busy(busy), .done(done), .state_dbg(state_dbg)
    );

    reg_dump #(.FIRST(5), .LAST(5)) dut_one (
        .clk(clk), .clr(clr), .start(start1), .abort(1'b0),
        .rd_addr(rd_addr1), .rd_data(rd_data1),
        .dout(dout1), .didx(didx1), .dvalid(dvalid1), .dready(dready1),
        .busy(busy1), .done(done1), .state_dbg(state_dbg1)
    );

    // ---------------- scoreboard ----------------
    logic [36:0] exp_q[$];   // {didx, dout}
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [36:0] obs, input logic [36:0] expv);
        n_tests++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_dump();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [36:0] e;
        int done_cnt;
        for (int i = 0; i < 32; i++) begin
            regs[i]  = 32'h1000_0000 + i;
            regs1[i] = '0;
        end
        regs1[5] = 32'hA5A5_A5A5;
        clr = 1'b1; start = 1'b0; abort = 1'b0; dready = 1'b1;
        start1 = 1'b0; dready1 = 1'b1;
        tick();
        tick();
        clr = 1'b0;

        // Reset state.
        check("rst_dout",    37'(dout), 37'h0);
        check("rst_didx",    37'(didx), 37'h0);
        check("rst_dvalid",  37'(dvalid), 37'h0);
        check("rst_busy",    37'(busy), 37'h0);
        check("rst_done",    37'(done), 37'h0);
        check("rst_rd_addr", 37'(rd_addr), 37'h0);
        check("rst_state",   37'(state_dbg), 37'h0);
        check("rst_rd_addr1", 37'(rd_addr1), 37'h5);

        // Full walk with dready held high; stray starts mid-dump are ignored.
        for (int n = 0; n < 32; n++) exp_q.push_back({5'(n), 32'h1000_0000 + n});
        start_dump();                                   // edge k
        check("full_busy_k", 37'(busy), 37'h1);
        check("full_addr_k", 37'(rd_addr), 37'h0);
        done_cnt = 0;
        for (int n = 0; n < 32; n++) begin
            if (n == 20) start = 1'b1;
            tick();                                     // edge k+1+2n: word captured
            start = 1'b0;
            e = exp_q.pop_front();
            check("full_word", {didx, dout}, e);
            check("full_valid", 37'(dvalid), 37'h1);
            if (n == 5) start = 1'b1;
            tick();                                     // edge k+2+2n: word accepted
            start = 1'b0;
            check("full_acc_valid", 37'(dvalid), 37'h0);
            if (done) done_cnt++;
            check("full_done", 37'(done), (n == 31) ? 37'h1 : 37'h0);
        end
        tick();                                         // edge k+65
        if (done) done_cnt++;
        check("full_done_cnt", 37'(done_cnt), 37'h1);
        check("full_busy_end", 37'(busy), 37'h0);
        check("full_state_end", 37'(state_dbg), 37'h0);
        tick();
        check("full_idle_valid", 37'(dvalid), 37'h0);

        // Stall on word 3 with the register rewritten underneath it.
        start_dump();
        repeat (7) tick();                              // word 3 now valid
        dready = 1'b0;
        check("stall_w3", {didx, dout}, {5'd3, 32'h1000_0003});
        regs[3] = 32'hDEAD_BEEF;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("stall_hold", {didx, dout}, {5'd3, 32'h1000_0003});
            check("stall_valid", 37'(dvalid), 37'h1);
        end
        dready = 1'b1;
        tick();
        check("stall_acc", 37'(dvalid), 37'h0);
        tick();
        check("stall_w4", {didx, dout}, {5'd4, 32'h1000_0004});
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("stall_abort_busy", 37'(busy), 37'h0);
        regs[3] = 32'h1000_0003;

        // Abort while word 7 is valid, coincident with a handshake.
        start_dump();
        repeat (15) tick();
        check("abort_w7", {didx, 37'(dvalid)}, {5'd7, 37'h1});
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_valid", 37'(dvalid), 37'h0);
        check("abort_busy",  37'(busy), 37'h0);
        check("abort_addr",  37'(rd_addr), 37'h0);
        check("abort_state", 37'(state_dbg), 37'h0);
        done_cnt = 0;
        for (int c = 0; c < 4; c++) begin
            if (done) done_cnt++;
            tick();
        end
        check("abort_no_done", 37'(done_cnt), 37'h0);
        start_dump();
        tick();
        check("abort_restart", {didx, dout}, {5'd0, 32'h1000_0000});

        // Clear while word 10 is waiting.
        repeat (20) tick();
        check("clr_w10", 37'(didx), 37'd10);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_out", {didx, dout}, 37'h0);
        check("clr_flags", 37'({dvalid, busy, done}), 37'h0);
        check("clr_addr", 37'(rd_addr), 37'h0);
        tick();
        check("clr_no_done", 37'(done), 37'h0);

        // Start together with abort while idle has no effect.
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("sa_busy", 37'(busy), 37'h0);
        check("sa_state", 37'(state_dbg), 37'h0);
        tick();
        check("sa_valid", 37'(dvalid), 37'h0);

        // Single-register dump, FIRST == LAST == 5.
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        check("one_busy", 37'(busy1), 37'h1);
        check("one_addr", 37'(rd_addr1), 37'h5);
        tick();
        check("one_word", {didx1, dout1}, {5'd5, 32'hA5A5_A5A5});
        check("one_valid", 37'(dvalid1), 37'h1);
        tick();
        check("one_done", 37'({dvalid1, done1, busy1}), 37'b011);
        tick();
        check("one_end", 37'({done1, busy1, state_dbg1}), 37'h0);
        tick();
        check("one_quiet", 37'({dvalid1, done1}), 37'h0);

        // ---------------- report ----------------
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
